pipe_issue_unit: RTL and testbench
==================================

# pipe_issue_unit

Front-end issue stage for `complex_pipeline`. It buffers packed instruction words from the sequencer, decodes them into the `rs1`/`rs2`/`rd`/`func`/`addr` fields the pipeline consumes, and issues at most one per cycle. The pipeline has no forwarding, so this unit enforces read-after-write spacing with a small scoreboard and inserts bubbles (`issue_valid = 0`) when the head instruction reads a register that is still in flight.

## Interface
Parameters:
- `DEPTH`, default 4: instruction FIFO entries; must be at least 2.
- `WB_LAT`, default 3: issue-to-writeback distance in edges. A dependent instruction may issue no earlier than `WB_LAT` edges after its producer. Must be at least 2.

Ports:
- `clk1`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: `in_instr` is valid.
- `in_ready`, out, 1: FIFO can accept a word; equals `!full`.
- `in_instr`, in, 24: `{func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}`.
- `flush`, in, 1: discards all queued instructions.
- `issue_valid`, out, 1: the fields below hold an issued instruction this cycle.
- `func`, out, 4: decoded field.
- `rd`, out, 4: decoded field.
- `rs1`, out, 4: decoded field.
- `rs2`, out, 4: decoded field.
- `addr`, out, 8: decoded field.
- `fifo_count`, out, `$clog2(DEPTH+1)`: occupancy.
- `stall_cnt`, out, 16: count of hazard-stall cycles; saturates at 16'hFFFF.

## Operation
- Push: occurs when `in_valid && in_ready && !flush`. `in_ready` has no combinational dependence on hazard or pop.
- Head check (combinational): `hazard` is true when the head's `rs1` or `rs2` equals `rd` in any valid scoreboard slot.
- Issue: occurs on an edge when the FIFO is non-empty, `!hazard` and `!flush`.
  - Pops the head.
  - Registers its fields.
  - Sets `issue_valid = 1`.
- No issue: `issue_valid = 0` and the fields hold their last values. The downstream stage must gate writes on `issue_valid`.
- Scoreboard: a shift register of `WB_LAT-1` slots, each `{valid, rd}`, advancing every edge.
  - Slot 0 loads `{1, rd}` on issue and `{0, x}` otherwise.
  - The oldest slot drops off.
  - All `WB_LAT-1` slots are compared.
- Stall counting: `stall_cnt` increments on an edge where the FIFO is non-empty, `hazard = 1` and `!flush`.
- Flush:
  - FIFO pointers and count clear on the edge.
  - Any push or issue on the same edge is suppressed; flush wins.
  - The scoreboard is not cleared, because issued instructions still retire.
  - `stall_cnt` is kept.
- Push while full: not possible, because `in_ready = 0`.
- Simultaneous push and issue with the FIFO non-full: both take effect and the count is unchanged.
- Push into an empty FIFO: the word can be issued on the next edge, not the same one.
- A write to the register currently at the head is not a hazard. WAW needs no check because writes retire in order.

## Timing
- Reset values, held while `rst` is high:
  - `issue_valid`, `func`, `rd`, `rs1`, `rs2`, `addr`, `fifo_count`, `stall_cnt` = 0.
  - Scoreboard all invalid; FIFO empty.
  - `in_ready` = 0.
- `in_ready` becomes 1 in the first cycle after `rst` deasserts.
- Latency: a word pushed at edge e into an empty, hazard-free unit is issued at edge e+1 and visible on the outputs during the cycle after e+1.
- Throughput: one instruction per cycle with no dependences.
- Bubble count: a dependent instruction directly behind its producer sees exactly `WB_LAT-1` bubbles. With the default, that is 2 bubbles.
- Reset mid-operation: the FIFO and scoreboard are discarded. In-flight instructions are not tracked after reset.

## Structure
- `pipe_pkg` holds:
  - `instr_t`, a packed struct with the field layout above.
  - Field-width localparams (`REG_W = 4`, `FUNC_W = 4`, `ADDR_W = 8`, `INSTR_W = 24`).
  - The `func` encodings: ADD = 0, SUB = 1, MUL = 2, SLA = 11.
- `pipe_instr_fifo` is a sub-module: synchronous FIFO with parameter `DEPTH`, signals push, pop, flush, full, empty and count, and a combinational head output.
- The scoreboard, hazard compare, issue register and stall counter live in `pipe_issue_unit`.

## Test plan
- Reset: hold `rst` for 2 cycles with `in_valid = 1`.
  - All outputs read 0 and nothing is pushed.
  - `in_ready = 1` in the first cycle after release.
- Independent stream: push ADD(3,5 to 10), MUL(3,8 to 12), SUB(7,4 to 13) back-to-back.
  - They issue on 3 consecutive edges with `issue_valid` high throughout.
  - `stall_cnt = 0`.
- RAW: push ADD(3,5 to 10), then SUB(10,5 to 14).
  - ADD issues at edge e and SUB at edge e+3.
  - `issue_valid = 0` for 2 cycles; `stall_cnt = 2`.
  - Repeat with `WB_LAT = 4`: 3 bubbles.
- Full FIFO: with `DEPTH = 4`, push a producer and then four instructions that depend on it, while `in_valid` stays high.
  - `in_ready` drops when `fifo_count = 4`.
  - The held word is accepted on the edge after the first pop.
  - No word is lost or duplicated.
- Flush: issue ADD(rd = 10), queue 3 words, then assert `flush`.
  - `fifo_count = 0` the next cycle and nothing further issues.
  - A SUB(rs1 = 10) pushed immediately afterwards still stalls until edge e+3 relative to the ADD.
- Reset mid-stream: assert `rst` with 2 words queued and one stalled.
  - All outputs are 0 and `fifo_count = 0` after the edge.
  - Next instruction issues with no stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the issue front-end: instruction layout, field widths and
// function encodings.
package pipe_pkg;

  localparam int REG_W   = 4;
  localparam int FUNC_W  = 4;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 24;

  typedef enum logic [FUNC_W-1:0] {
    FN_ADD = 4'd0,
    FN_SUB = 4'd1,
    FN_MUL = 4'd2,
    FN_SLA = 4'd11
  } func_e;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [ADDR_W-1:0] addr;
  } instr_t;

endpackage

// File: rtl/pipe_instr_fifo.sv
// Synchronous instruction FIFO with flush and a combinational head output.
// Pointers wrap explicitly so DEPTH need not be a power of two.
module pipe_instr_fifo
  import pipe_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH+1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  instr_t           data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output instr_t           head_o
);

  instr_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // flush wins over any same-edge push or pop
  assign do_push = push_i && !full_o  && !flush_i;
  assign do_pop  = pop_i  && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pipe_issue_unit.sv
// Issue stage: buffers instructions, holds back RAW-dependent heads with a
// WB_LAT-1 deep destination scoreboard, and issues at most one per cycle.
module pipe_issue_unit
  import pipe_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WB_LAT = 3
) (
  input  logic                       clk1,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic                       flush,
  output logic                       issue_valid,
  output logic [FUNC_W-1:0]          func,
  output logic [REG_W-1:0]           rd,
  output logic [REG_W-1:0]           rs1,
  output logic [REG_W-1:0]           rs2,
  output logic [ADDR_W-1:0]          addr,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [15:0]                stall_cnt
);

  localparam int SB_N = WB_LAT - 1;

  instr_t head;
  logic   full, empty, hazard, issue, stall_ev;

  logic [SB_N-1:0]            sb_vld_q, sb_vld_d;
  logic [SB_N-1:0][REG_W-1:0] sb_rd_q,  sb_rd_d;
  logic                       iv_q;
  instr_t                     iss_q, iss_d;
  logic [15:0]                stall_q, stall_d;

  // ready is forced low during reset so nothing is taken while rst is held
  assign in_ready = !full && !rst;

  pipe_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk1),
    .rst_i   (rst),
    .push_i  (in_valid && in_ready),
    .data_i  (instr_t'(in_instr)),
    .pop_i   (issue),
    .flush_i (flush),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count),
    .head_o  (head)
  );

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_N; i++)
      if (sb_vld_q[i] && (sb_rd_q[i] == head.rs1 || sb_rd_q[i] == head.rs2)) hazard = 1'b1;
  end

  assign issue    = !empty && !hazard && !flush;
  assign stall_ev = !empty &&  hazard && !flush;

  // scoreboard keeps shifting through flush: issued work still retires
  always_comb begin
    sb_vld_d = sb_vld_q;
    sb_rd_d  = sb_rd_q;
    for (int i = SB_N-1; i > 0; i--) begin
      sb_vld_d[i] = sb_vld_q[i-1];
      sb_rd_d[i]  = sb_rd_q[i-1];
    end
    sb_vld_d[0] = issue;
    sb_rd_d[0]  = head.rd;
  end

  always_comb begin
    iss_d   = issue ? head : iss_q;
    stall_d = (stall_ev && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      sb_vld_q <= '0;
      sb_rd_q  <= '0;
      iv_q     <= 1'b0;
      iss_q    <= '0;
      stall_q  <= '0;
    end else begin
      sb_vld_q <= sb_vld_d;
      sb_rd_q  <= sb_rd_d;
      iv_q     <= issue;
      iss_q    <= iss_d;
      stall_q  <= stall_d;
    end
  end

  assign issue_valid = iv_q;
  assign func        = iss_q.func;
  assign rd          = iss_q.rd;
  assign rs1         = iss_q.rs1;
  assign rs2         = iss_q.rs2;
  assign addr        = iss_q.addr;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipe_issue_unit.sv
// Directed bench for pipe_issue_unit: two instances (WB_LAT 3 and 4) share
// stimulus; each step checks hand-derived outputs one cycle after the edge.
module tb_pipe_issue_unit;
  import pipe_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst, in_valid, flush;
  logic [23:0] in_instr;

  logic        rdy1, iv1, rdy2, iv2;
  logic [3:0]  func1, rd1, rs11, rs21, func2, rd2, rs12, rs22;
  logic [7:0]  addr1, addr2;
  logic [2:0]  cnt1, cnt2;
  logic [15:0] st1, st2;

  int errors = 0;
  int checks = 0;

  always #5 clk1 = ~clk1;

  pipe_issue_unit #(.DEPTH(4), .WB_LAT(3)) dut1 (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_instr(in_instr),
    .flush(flush), .issue_valid(iv1), .func(func1), .rd(rd1), .rs1(rs11), .rs2(rs21),
    .addr(addr1), .fifo_count(cnt1), .stall_cnt(st1)
  );

  pipe_issue_unit #(.DEPTH(4), .WB_LAT(4)) dut2 (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_instr(in_instr),
    .flush(flush), .issue_valid(iv2), .func(func2), .rd(rd2), .rs1(rs12), .rs2(rs22),
    .addr(addr2), .fifo_count(cnt2), .stall_cnt(st2)
  );

  function automatic logic [23:0] mk(input logic [3:0] f, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2,
                                     input logic [7:0] a);
    return {f, d, s1, s2, a};
  endfunction

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; flush = 1'b0;
    in_instr = mk(FN_ADD, 4'd10, 4'd3, 4'd5, 8'h11);

    // reset held two cycles with in_valid high
    tick(); tick();
    chk("rst_iv",    iv1, 0);
    chk("rst_rdy",   rdy1, 0);
    chk("rst_fields", {func1, rd1, rs11, rs21, addr1}, 0);
    chk("rst_cnt",   cnt1, 0);
    chk("rst_stall", st1, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rel_rdy", rdy1, 1);
    chk("rel_cnt", cnt1, 0);

    // independent stream
    in_valid = 1'b1; in_instr = mk(FN_ADD, 4'd10, 4'd3, 4'd5, 8'h01);
    tick();
    chk("ind_cnt0", cnt1, 1);
    chk("ind_iv0",  iv1, 0);
    in_instr = mk(FN_MUL, 4'd12, 4'd3, 4'd8, 8'h02);
    tick();
    chk("ind_add", {iv1, func1, rd1, rs11, rs21, addr1}, {1'b1, 4'd0, 4'd10, 4'd3, 4'd5, 8'h01});
    in_instr = mk(FN_SUB, 4'd13, 4'd7, 4'd4, 8'h03);
    tick();
    chk("ind_mul", {iv1, func1, rd1}, {1'b1, 4'd2, 4'd12});
    in_valid = 1'b0;
    tick();
    chk("ind_sub", {iv1, func1, rd1, rs11, rs21, addr1}, {1'b1, 4'd1, 4'd13, 4'd7, 4'd4, 8'h03});
    tick();
    chk("ind_idle",  {iv1, cnt1}, 0);
    chk("ind_stall", st1, 0);

    // RAW: ADD then dependent SUB
    do_reset();
    in_valid = 1'b1; in_instr = mk(FN_ADD, 4'd10, 4'd3, 4'd5, 8'h00);
    tick();
    in_instr = mk(FN_SUB, 4'd14, 4'd10, 4'd5, 8'h00);
    tick();
    chk("raw_add", {iv1, rd1}, {1'b1, 4'd10});
    in_valid = 1'b0;
    tick();
    chk("raw_b1", iv1, 0);
    tick();
    chk("raw_b2", iv1, 0);
    tick();
    chk("raw_sub",   {iv1, rd1, func1}, {1'b1, 4'd14, 4'd1});
    chk("raw_st",    st1, 2);
    chk("raw4_b3",   iv2, 0);
    tick();
    chk("raw4_sub",  {iv2, rd2}, {1'b1, 4'd14});
    chk("raw4_st",   st2, 3);
    chk("raw_after", {iv1, st1}, {1'b0, 16'd2});

    // full FIFO on the WB_LAT=4 instance
    do_reset();
    in_valid = 1'b1; in_instr = mk(FN_ADD, 4'd10, 4'd3, 4'd5, 8'h00);
    tick();
    in_instr = mk(FN_SUB, 4'd1, 4'd10, 4'd0, 8'h01);
    tick();
    chk("full_p", {iv2, rd2}, {1'b1, 4'd10});
    in_instr = mk(FN_SUB, 4'd2, 4'd10, 4'd0, 8'h02);
    tick();
    in_instr = mk(FN_SUB, 4'd3, 4'd10, 4'd0, 8'h03);
    tick();
    in_instr = mk(FN_SUB, 4'd4, 4'd10, 4'd0, 8'h04);
    tick();
    chk("full_cnt4", cnt2, 4);
    chk("full_rdy0", rdy2, 0);
    in_instr = mk(FN_SLA, 4'd5, 4'd6, 4'd7, 8'h05);
    tick();
    chk("full_rdy1", rdy2, 1);
    chk("full_d1",   {iv2, rd2, cnt2}, {1'b1, 4'd1, 3'd3});
    tick();
    in_valid = 1'b0;
    chk("full_d2",   {iv2, rd2, cnt2}, {1'b1, 4'd2, 3'd3});
    tick();
    chk("full_d3",   {iv2, rd2}, {1'b1, 4'd3});
    tick();
    chk("full_d4",   {iv2, rd2, addr2}, {1'b1, 4'd4, 8'h04});
    tick();
    chk("full_w5",   {iv2, func2, rd2, cnt2}, {1'b1, 4'd11, 4'd5, 3'd0});
    tick();
    chk("full_end",  {iv2, cnt2}, 0);
    chk("full_st",   st2, 3);

    // flush with a freshly issued producer still in flight
    do_reset();
    in_valid = 1'b1; in_instr = mk(FN_MUL, 4'd3, 4'd1, 4'd2, 8'h00);
    tick();
    in_instr = mk(FN_ADD, 4'd10, 4'd3, 4'd5, 8'h00);
    tick();
    in_instr = mk(FN_SUB, 4'd1, 4'd10, 4'd0, 8'h01);
    tick();
    in_instr = mk(FN_SUB, 4'd2, 4'd10, 4'd0, 8'h02);
    tick();
    in_instr = mk(FN_SUB, 4'd3, 4'd10, 4'd0, 8'h03);
    tick();
    chk("fl_add1", {iv1, rd1, cnt1}, {1'b1, 4'd10, 3'd3});
    chk("fl_cnt2", cnt2, 4);
    in_valid = 1'b0;
    tick();
    chk("fl_add2", {iv2, rd2, cnt2}, {1'b1, 4'd10, 3'd3});
    chk("fl_st1a", iv1, 0);
    flush = 1'b1;
    tick();
    chk("fl_clr", {cnt1, cnt2, iv1, iv2}, 0);
    flush = 1'b0; in_valid = 1'b1; in_instr = mk(FN_SUB, 4'd14, 4'd10, 4'd5, 8'h00);
    tick();
    chk("fl_none", {iv1, iv2, cnt1}, {1'b0, 1'b0, 3'd1});
    in_valid = 1'b0;
    tick();
    chk("fl_sub1", {iv1, rd1, st1}, {1'b1, 4'd14, 16'd3});
    chk("fl_hold2", iv2, 0);
    tick();
    chk("fl_sub2", {iv2, rd2, st2}, {1'b1, 4'd14, 16'd4});

    // reset mid-stream
    do_reset();
    in_valid = 1'b1; in_instr = mk(FN_ADD, 4'd10, 4'd3, 4'd5, 8'h00);
    tick();
    in_instr = mk(FN_SUB, 4'd11, 4'd10, 4'd5, 8'h00);
    tick();
    in_instr = mk(FN_SUB, 4'd12, 4'd10, 4'd6, 8'h00);
    tick();
    chk("mr_cnt", {cnt1, st1}, {3'd2, 16'd1});
    in_valid = 1'b0; rst = 1'b1;
    tick();
    chk("mr_zero", {iv1, func1, rd1, rs11, rs21, addr1, cnt1, st1, rdy1}, 0);
    rst = 1'b0; in_valid = 1'b1; in_instr = mk(FN_SUB, 4'd13, 4'd10, 4'd5, 8'h07);
    tick();
    in_valid = 1'b0;
    tick();
    chk("mr_issue1", {iv1, rd1, addr1, st1}, {1'b1, 4'd13, 8'h07, 16'd0});
    chk("mr_issue2", {iv2, rd2, st2}, {1'b1, 4'd13, 16'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
